// File: rtl/hsclk_div_m.sv
// -----------------------------------------------------------------------------
// hsclk_div_m
//
// Programmable divider for the high-speed clock. Produces the divided clock
// that feeds the CPU clock selector. The divide ratio comes from the two
// clock-divider bits of the CPLD map register. That request is asynchronous to
// hsclk, so it is synchronised first. It is then applied only on the
// high->low edge of clkout, so every period (low phase then high phase) runs
// entirely at one ratio and no runt phase can appear.
//
//   phase length = active_sel + 1 hsclk cycles, period = 2 * (active_sel + 1)
//
// Optional feature, enabled by defining HSCLK_DIV_STRETCH_EN:
//   stretch=1 at the end of a low phase holds clkout low. clkout then rises
//   normally, with rise_stb, on the first cycle where stretch=0. The high phase
//   is never stretched. Without the macro the stretch port is ignored.
//
// Parameters:
//   DIV_SEL_SZ  width of the divide-select input
//   CNT_SZ      width of the phase counter, must be >= DIV_SEL_SZ
//
// Ports:
//   hsclk       in   high-speed source clock, all flops clock on its rising edge
//   resetb      in   asynchronous active-low reset
//   div_sel     in   requested ratio, asynchronous to hsclk
//   stretch     in   hold-low request (optional feature only)
//   clkout      out  divided clock, registered, 50% duty cycle
//   rise_stb    out  high during the first hsclk cycle of each clkout high phase
//   div_busy    out  a synchronised ratio request is waiting to be applied
//   active_sel  out  ratio currently in force
// -----------------------------------------------------------------------------
module hsclk_div_m #(
    parameter int DIV_SEL_SZ = 2,
    parameter int CNT_SZ     = 2
) (
    input  logic                  hsclk,
    input  logic                  resetb,
    input  logic [DIV_SEL_SZ-1:0] div_sel,
    input  logic                  stretch,
    output logic                  clkout,
    output logic                  rise_stb,
    output logic                  div_busy,
    output logic [DIV_SEL_SZ-1:0] active_sel
);

    logic [DIV_SEL_SZ-1:0] sync1_q, sync1_d;
    logic [DIV_SEL_SZ-1:0] sync2_q, sync2_d;
    logic [DIV_SEL_SZ-1:0] active_sel_q, active_sel_d;
    logic [CNT_SZ-1:0]     cnt_q, cnt_d;
    logic                  clkout_q, clkout_d;
    logic                  rise_stb_q, rise_stb_d;
    logic                  div_busy_q, div_busy_d;

    logic                  phase_end;
    logic                  hold_low;

`ifndef HSCLK_DIV_STRETCH_EN
    // The port stays on the boundary so both builds share one pin list.
    logic unused_stretch;
    assign unused_stretch = stretch;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and turn it into a latch.
        sync1_d      = div_sel;
        sync2_d      = sync1_q;
        clkout_d     = clkout_q;
        cnt_d        = cnt_q + CNT_SZ'(1);
        rise_stb_d   = 1'b0;
        active_sel_d = active_sel_q;
        hold_low     = 1'b0;

        // The counter never passes active_sel: active_sel only changes when
        // cnt is cleared, so the equality below is the only wrap point.
        phase_end = (cnt_q == CNT_SZ'(active_sel_q));

`ifdef HSCLK_DIV_STRETCH_EN
        // Only a low phase can be extended. The high phase is always exact.
        hold_low = stretch && !clkout_q;
`endif

        if (phase_end) begin
            if (hold_low) begin
                cnt_d = cnt_q;
            end else begin
                clkout_d   = ~clkout_q;
                cnt_d      = '0;
                // The strobe is registered alongside clkout, so both read 1
                // in the same cycle.
                rise_stb_d = ~clkout_q;
                // Apply a new ratio only as the high phase ends. The next
                // low and high phases then share the same length.
                if (clkout_q) begin
                    active_sel_d = sync2_q;
                end
            end
        end

        // The flag compares against the ratio currently in force. It
        // therefore drops one cycle after the request is applied.
        div_busy_d = (sync2_q != active_sel_q);
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge hsclk or negedge resetb) begin
        if (!resetb) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            active_sel_q <= '0;
            cnt_q        <= '0;
            clkout_q     <= 1'b0;
            rise_stb_q   <= 1'b0;
            div_busy_q   <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            active_sel_q <= active_sel_d;
            cnt_q        <= cnt_d;
            clkout_q     <= clkout_d;
            rise_stb_q   <= rise_stb_d;
            div_busy_q   <= div_busy_d;
        end
    end

    assign clkout     = clkout_q;
    assign rise_stb   = rise_stb_q;
    assign div_busy   = div_busy_q;
    assign active_sel = active_sel_q;

endmodule

// File: tb/tb_hsclk_div_m.sv
// -----------------------------------------------------------------------------
// tb_hsclk_div_m
//
// Scoreboard bench for hsclk_div_m. On every rising edge, a reference model
// describes the expected output in terms of phases. Each phase lasts
// ratio+1 cycles. A low phase may be held by stretch, and a new ratio is taken
// when a high phase ends. The model pushes the expected outputs into a queue.
// A separate monitor pops that queue on each falling edge and compares it with
// the DUT. The stimulus covers the directed scenarios, then a randomised run.
// Define HSCLK_DIV_STRETCH_EN for both the bench and the RTL to exercise the
// stretch feature.
// -----------------------------------------------------------------------------
module tb_hsclk_div_m;

    localparam int W = 2;
`ifdef HSCLK_DIV_STRETCH_EN
    localparam bit STRETCH_EN = 1'b1;
`else
    localparam bit STRETCH_EN = 1'b0;
`endif

    typedef struct packed {
        logic         clkout;
        logic         rise_stb;
        logic         div_busy;
        logic [W-1:0] active_sel;
    } obs_t;

    logic         hsclk   = 1'b0;
    logic         resetb  = 1'b0;
    logic [W-1:0] div_sel = '0;
    logic         stretch = 1'b0;
    logic         clkout;
    logic         rise_stb;
    logic         div_busy;
    logic [W-1:0] active_sel;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    obs_t exp_q[$];

    hsclk_div_m #(.DIV_SEL_SZ(W), .CNT_SZ(2)) dut (
        .hsclk      (hsclk),
        .resetb     (resetb),
        .div_sel    (div_sel),
        .stretch    (stretch),
        .clkout     (clkout),
        .rise_stb   (rise_stb),
        .div_busy   (div_busy),
        .active_sel (active_sel)
    );

    always #5 hsclk = ~hsclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: phase-level description of the divided clock
    // ---------------------------------------------------------------------
    int m_level;    // current clkout level
    int m_left;     // cycles left in the current phase
    int m_ratio;    // ratio in force
    int m_busy;
    int m_rise;
    int m_seen1;    // div_sel seen one edge ago
    int m_seen2;    // div_sel seen two edges ago (the synchronised request)

    task automatic model_reset();
        m_level = 0;
        m_left  = 1;   // after reset the first edge ends a 1-cycle low phase
        m_ratio = 0;
        m_busy  = 0;
        m_rise  = 0;
        m_seen1 = 0;
        m_seen2 = 0;
    endtask

    task automatic model_step();
        int req;
        req     = m_seen2;
        m_busy  = (req != m_ratio) ? 1 : 0;
        m_seen2 = m_seen1;
        m_seen1 = int'(div_sel);
        m_rise  = 0;
        m_left  = m_left - 1;
        if (m_left == 0) begin
            if (m_level == 0) begin
                if (STRETCH_EN && stretch) begin
                    m_left = 1;
                end else begin
                    m_level = 1;
                    m_rise  = 1;
                    m_left  = m_ratio + 1;
                end
            end else begin
                m_level = 0;
                m_ratio = req;
                m_left  = m_ratio + 1;
            end
        end
    endtask

    initial begin
        obs_t e;
        model_reset();
        forever begin
            @(posedge hsclk);
            if (!resetb) model_reset();
            else         model_step();
            e.clkout     = (m_level != 0);
            e.rise_stb   = (m_rise != 0);
            e.div_busy   = (m_busy != 0);
            e.active_sel = W'(m_ratio);
            exp_q.push_back(e);
        end
    end

    // ---------------------------------------------------------------------
    // Monitor: compare the DUT with the scoreboard on each falling edge
    // ---------------------------------------------------------------------
    initial begin
        obs_t e;
        obs_t a;
        @(posedge hsclk);
        forever begin
            @(negedge hsclk);
            cyc++;
            a = {clkout, rise_stb, div_busy, active_sel};
            if (exp_q.size() == 0) begin
                bad++;
                total++;
                $display("FAIL scoreboard_empty cyc %0d: actual=%0h required=entry", cyc, a);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("cyc%0d {clkout,rise,busy,sel}", cyc), 32'(a), 32'(e));
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus: inputs change 1 time unit after the falling edge
    // ---------------------------------------------------------------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge hsclk);
            #1;
        end
    endtask

    // Return inside the first high cycle of the next clkout period.
    task automatic wait_rise(input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge hsclk);
            if (rise_stb === 1'b1) found = 1'b1;
        end
        #1;
        check(name, 32'(found), 32'd1);
    endtask

    initial begin
        // Reset held while a /8 request is presented
        resetb  = 1'b0;
        div_sel = 2'd3;
        stretch = 1'b0;
        cycles(4);
        // Release: /2 first, then /8 after the first apply point
        resetb = 1'b1;
        cycles(40);

        // Running at /4, switch to /6 during the first high cycle
        div_sel = 2'd1;
        cycles(30);
        wait_rise("wait_rise_sel1");
        div_sel = 2'd2;
        cycles(30);

        // One-cycle glitch request while running at /2
        div_sel = 2'd0;
        cycles(30);
        div_sel = 2'd3;
        cycles(1);
        div_sel = 2'd0;
        cycles(16);

        // Reset in the third cycle of a /8 high phase
        div_sel = 2'd3;
        cycles(30);
        wait_rise("wait_rise_sel3");
        cycles(2);
        div_sel = 2'd0;
        resetb  = 1'b0;
        #1;
        check("async_reset_clkout", 32'(clkout), 32'd0);
        check("async_reset_active_sel", 32'(active_sel), 32'd0);
        check("async_reset_div_busy", 32'(div_busy), 32'd0);
        cycles(2);
        resetb = 1'b1;
        cycles(16);

        // Stretch across a low-phase end at /4
        div_sel = 2'd1;
        cycles(30);
        wait_rise("wait_rise_stretch");
        stretch = 1'b1;
        cycles(5);
        stretch = 1'b0;
        cycles(20);

        // Randomised run with ratio changes, stretch and occasional reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) div_sel = W'($urandom_range(0, 3));
            stretch = ($urandom_range(0, 3) == 0);
            resetb  = ($urandom_range(0, 149) != 0);
            cycles(1);
        end
        resetb  = 1'b1;
        stretch = 1'b0;
        cycles(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
